// File: rtl/rp_scope_calib_pkg.sv
// rtl/rp_scope_calib_pkg.sv - shared types and constants for the scope calibration sequencer
package rp_scope_calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    CALC,
    APPLY
  } calib_state_e;

  localparam logic [15:0] UNITY_GAIN = 16'h8000;

  // Signed saturation limits for a DBITS-wide offset, shared with the calib datapath.
  function automatic int calc_max(input int dbits);
    return (1 << (dbits - 1)) - 1;
  endfunction

  function automatic int calc_min(input int dbits);
    return -(1 << (dbits - 1));
  endfunction

endpackage

// File: rtl/rp_calib_accum.sv
// rtl/rp_calib_accum.sv - clear/enable sample accumulator with 2^AVG_LOG2 sample counter
module rp_calib_accum #(
  parameter int DBITS    = 16,
  parameter int AVG_LOG2 = 10
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clr_i,
  input  logic                               en_i,
  input  logic signed [DBITS-1:0]            dat_i,
  output logic signed [DBITS+AVG_LOG2-1:0]   acc_o,
  output logic                               last_o
);

  logic signed [DBITS+AVG_LOG2-1:0] acc_q, acc_d;
  logic [AVG_LOG2-1:0]              cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + $signed({{AVG_LOG2{dat_i[DBITS-1]}}, dat_i});
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o = acc_q;
  // High when the next accepted sample completes the 2^AVG_LOG2 window.
  assign last_o = &cnt_q;

endmodule

// File: rtl/rp_scope_calib_ctrl.sv
// rtl/rp_scope_calib_ctrl.sv - auto-offset calibration sequencer and offset/gain mux for one scope channel
// Optional build macro RP_CALIB_TIMEOUT_EN adds a no-valid-sample timeout in SETTLE/ACCUM.
module rp_scope_calib_ctrl
  import rp_scope_calib_pkg::*;
#(
  parameter int          DBITS      = 16,
  parameter int          AVG_LOG2   = 10,
  parameter int          SETTLE_SMP = 64,
  parameter int unsigned TMO_CYC    = 2**20
) (
  input  logic                    adc_clk_i,
  input  logic                    adc_rstn_i,
  input  logic signed [DBITS-1:0] adc_dat_i,
  input  logic                    adc_dat_tvalid_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    auto_mode_i,
  input  logic signed [DBITS-1:0] sw_offset_i,
  input  logic [15:0]             sw_gain_i,
  output logic signed [DBITS-1:0] cfg_calib_offset_o,
  output logic [15:0]             cfg_calib_gain_o,
  output logic signed [DBITS-1:0] auto_offset_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sat_o,
  output logic                    err_o
);

  localparam int AW = DBITS + AVG_LOG2;
  localparam int SW = (SETTLE_SMP > 1) ? $clog2(SETTLE_SMP) : 1;
  localparam logic signed [AW-1:0]    HALF    = AW'(1 << (AVG_LOG2 - 1));
  localparam logic signed [DBITS-1:0] RES_MAX = DBITS'(calc_max(DBITS));
  localparam logic signed [DBITS-1:0] RES_MIN = DBITS'(calc_min(DBITS));

  calib_state_e            state_q, state_d;
  logic [SW-1:0]           settle_cnt_q, settle_cnt_d;
  logic signed [DBITS-1:0] res_q, res_d;
  logic signed [DBITS-1:0] auto_offset_q, auto_offset_d;
  logic signed [DBITS-1:0] cfg_offset_q, cfg_offset_d;
  logic [15:0]             cfg_gain_q, cfg_gain_d;
  logic                    done_q, done_d;
  logic                    sat_q, sat_d;
  logic                    err_q, err_d;

  logic                    acc_clr, acc_en, acc_last, tmo_hit;
  logic signed [AW-1:0]    acc;
  logic signed [DBITS-1:0] mean;
  logic                    calc_sat;

  rp_calib_accum #(
    .DBITS    (DBITS),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk_i  (adc_clk_i),
    .rst_ni (adc_rstn_i),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .dat_i  (adc_dat_i),
    .acc_o  (acc),
    .last_o (acc_last)
  );

  // Round half up, then the only value whose negation overflows is the most negative mean.
  assign mean     = DBITS'((acc + HALF) >>> AVG_LOG2);
  assign calc_sat = (mean == RES_MIN);

`ifdef RP_CALIB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == SETTLE || state_q == ACCUM) && !adc_dat_tvalid_i) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == SETTLE || state_q == ACCUM) && !adc_dat_tvalid_i &&
                   (tmo_cnt_q == TW'(TMO_CYC - 1));

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) tmo_cnt_q <= '0;
    else             tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    res_d         = res_q;
    auto_offset_d = auto_offset_q;
    sat_d         = sat_q;
    err_d         = err_q;
    done_d        = 1'b0;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;
    cfg_offset_d  = auto_mode_i ? auto_offset_q : sw_offset_i;
    cfg_gain_d    = sw_gain_i;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          sat_d        = 1'b0;
          err_d        = 1'b0;
          acc_clr      = 1'b1;
        end
      end
      SETTLE: begin
        if (abort_i || tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (SETTLE_SMP == 0) begin
          state_d = ACCUM;
        end else if (adc_dat_tvalid_i) begin
          if (settle_cnt_q == SW'(SETTLE_SMP - 1)) state_d = ACCUM;
          else settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ACCUM: begin
        if (abort_i || tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (adc_dat_tvalid_i) begin
          acc_en = 1'b1;
          if (acc_last) state_d = CALC;
        end
      end
      CALC: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          res_d   = calc_sat ? RES_MAX : -mean;
          sat_d   = calc_sat;
          state_d = APPLY;
        end
      end
      APPLY: begin
        auto_offset_d = res_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      res_q         <= '0;
      auto_offset_q <= '0;
      cfg_offset_q  <= '0;
      cfg_gain_q    <= '0;
      done_q        <= 1'b0;
      sat_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      res_q         <= res_d;
      auto_offset_q <= auto_offset_d;
      cfg_offset_q  <= cfg_offset_d;
      cfg_gain_q    <= cfg_gain_d;
      done_q        <= done_d;
      sat_q         <= sat_d;
      err_q         <= err_d;
    end
  end

  assign cfg_calib_offset_o = cfg_offset_q;
  assign cfg_calib_gain_o   = cfg_gain_q;
  assign auto_offset_o      = auto_offset_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign sat_o              = sat_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_rp_scope_calib_ctrl.sv
// tb/tb_rp_scope_calib_ctrl.sv - randomized self-checking bench for rp_scope_calib_ctrl
module tb_rp_scope_calib_ctrl;
  import rp_scope_calib_pkg::*;

  localparam int SS = 2;
  localparam int NS = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [15:0] dat;
  logic               vld, start, abort, amode;
  logic signed [15:0] sw_off;
  logic [15:0]        sw_gain;
  logic signed [15:0] cfg_off;
  logic [15:0]        cfg_gain;
  logic signed [15:0] auto_off;
  logic               busy, done, sat, err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_auto = 0;

  always #5 clk = ~clk;

  rp_scope_calib_ctrl #(
    .DBITS      (16),
    .AVG_LOG2   (4),
    .SETTLE_SMP (SS),
    .TMO_CYC    (32)
  ) dut (
    .adc_clk_i          (clk),
    .adc_rstn_i         (rstn),
    .adc_dat_i          (dat),
    .adc_dat_tvalid_i   (vld),
    .start_i            (start),
    .abort_i            (abort),
    .auto_mode_i        (amode),
    .sw_offset_i        (sw_off),
    .sw_gain_i          (sw_gain),
    .cfg_calib_offset_o (cfg_off),
    .cfg_calib_gain_o   (cfg_gain),
    .auto_offset_o      (auto_off),
    .busy_o             (busy),
    .done_o             (done),
    .sat_o              (sat),
    .err_o              (err)
  );

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind: 0 constant cval, 1 alternating 3/4, 2 random; vmode: 0 every cycle, 1 one-in-three, 2 random.
  task automatic run_cal(input int kind, input int cval, input int vmode, input int abort_n, input bit am);
    int nval = 0, last = -1, ab_cyc = -1, done_cyc = -1;
    int bad_busy = 0, bad_clr = 0, got_auto = 0, got_sat = 0, d, mean, exp_res, exp_sat;
    bit fin = 0, v, eb;
    longint sum = 0;
    sw_off  = 16'($urandom);
    sw_gain = (kind == 0) ? UNITY_GAIN : 16'($urandom);
    amode   = am;
    abort   = 1'b0;
    vld     = 1'($urandom);
    dat     = 16'($urandom);
    start   = 1'b1;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      eb = (ab_cyc >= 0) ? (cyc <= ab_cyc) : (last < 0 || cyc <= last + 2);
      if (busy !== eb) bad_busy++;
      if (cyc == 1 && (sat !== 1'b0 || err !== 1'b0)) bad_clr++;
      if (done === 1'b1) begin
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got_auto = auto_off;
          got_sat  = sat;
        end else bad_busy++;
      end
      if ((last >= 0 && cyc == last + 4) || (ab_cyc >= 0 && cyc == ab_cyc + 2)) fin = 1'b1;
      else begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = (cyc % 3 == 0);
          default: v = 1'($urandom);
        endcase
        d = (kind == 0) ? cval : (kind == 1) ? ((nval % 2 != 0) ? 4 : 3) : int'($signed(16'($urandom)));
        vld = v;
        dat = 16'(d);
        if (v && last < 0 && ab_cyc < 0) begin
          if (abort_n > 0 && nval == SS + abort_n - 1) begin
            abort  = 1'b1;
            ab_cyc = cyc;
          end else begin
            if (nval >= SS) sum += d;
            nval++;
            if (nval == SS + NS) last = cyc;
          end
        end
        if (last < 0 && ab_cyc < 0 && !abort && ($urandom % 8 == 0)) start = 1'b1;
      end
    end
    vld = 1'b0;
    chk_eq("run_bounded", fin, 1);
    chk_eq("busy_trace", bad_busy, 0);
    chk_eq("clear_on_start", bad_clr, 0);
    if (abort_n > 0) begin
      chk_eq("abort_no_done", done_cyc, -1);
      chk_eq("abort_err", err, 1);
      chk_eq("abort_hold_offset", auto_off, exp_auto);
    end else begin
      mean    = int'($floor((real'(sum) + 8.0) / 16.0));
      exp_res = -mean;
      exp_sat = 0;
      if (exp_res > 32767) begin
        exp_res = 32767;
        exp_sat = 1;
      end
      chk_eq("done_latency", done_cyc, last + 3);
      chk_eq("auto_offset", got_auto, exp_res);
      chk_eq("sat", got_sat, exp_sat);
      chk_eq("err_clear", err, 0);
      exp_auto = exp_res;
      chk_eq("cfg_offset", cfg_off, am ? exp_res : int'(sw_off));
      chk_eq("cfg_gain", cfg_gain, sw_gain);
    end
  endtask

  initial begin
    rstn = 1'b0; dat = '0; vld = 1'b0; start = 1'b0; abort = 1'b0;
    amode = 1'b0; sw_off = '0; sw_gain = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_flags", {done, sat, err}, 0);
    chk_eq("rst_auto", auto_off, 0);
    chk_eq("rst_cfg", {cfg_off, cfg_gain}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_cal(0, -100, 0, 0, 1'b1);
    run_cal(1, 0, 0, 0, 1'b1);
    run_cal(0, -32768, 0, 0, 1'b0);
    run_cal(0, -100, 1, 0, 1'b1);
    run_cal(2, 0, 0, 8, 1'b1);

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk_eq("start_abort_idle", busy, 0);
    chk_eq("start_abort_err_sticky", err, 1);

    for (int i = 0; i < 6; i++) run_cal(2, 0, int'($urandom % 3), 0, 1'($urandom));
    run_cal(2, 0, 2, 1 + int'($urandom % 15), 1'b1);

    start = 1'b1; vld = 1'b1; dat = -16'sd100; amode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_eq("async_rst_busy", busy, 0);
    chk_eq("async_rst_outs", {done, sat, err, auto_off, cfg_off, cfg_gain}, 0);
    @(posedge clk); #1;
    rstn = 1'b1; vld = 1'b0;
    exp_auto = 0;
    @(posedge clk); #1;
    chk_eq("post_rst_idle", busy, 0);
    run_cal(0, 250, 2, 0, 1'b1);

`ifdef RP_CALIB_TIMEOUT_EN
    start = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; vld = 1'b1; dat = '0;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk_eq("tmo_not_yet", {busy, err}, 2'b10);
    @(posedge clk); #1;
    chk_eq("tmo_fired", {busy, err}, 2'b01);
    chk_eq("tmo_hold_offset", auto_off, exp_auto);
`else
    start = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; vld = 1'b1; dat = '0;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk_eq("no_tmo_waiting", {busy, err}, 2'b10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_eq("no_tmo_abort", {busy, err}, 2'b01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
